// File: rtl/residue_vote_pkg.sv
// Shared io package for the mod-14 residue path: sizes, residue width and
// the vote FSM encoding.
package residue_vote_pkg;

    localparam int RV_NUM_BINS = 14;
    localparam int RV_CNT_W    = 8;
    localparam int RES_W       = 8;
    localparam int CLS_W       = 4;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_SCAN   = 2'd1,
        ST_OUTPUT = 2'd2
    } rv_state_e;

endpackage

// File: rtl/residue_vote.sv
// Per-frame residue histogram with a one-bin-per-cycle argmax scan.
// Handshake: a beat moves when in_valid && in_ready, a result when out_valid && out_ready.
module residue_vote
    import residue_vote_pkg::*;
#(
    parameter int NUM_BINS = RV_NUM_BINS,
    parameter int CNT_W    = RV_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RES_W-1:0] in_residue,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CLS_W-1:0] out_class,
    output logic [CNT_W-1:0] out_count,
    output logic             out_err,
    output rv_state_e        dbg_state
);

    rv_state_e        state_q, state_d;
    logic [CNT_W-1:0] bin_q [NUM_BINS];
    logic [CNT_W-1:0] bin_d [NUM_BINS];
    logic [IDX_W-1:0] scan_q, scan_d;
    logic [CLS_W-1:0] cls_q, cls_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cur_bin;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        scan_d  = scan_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cur_bin = '0;
        for (int i = 0; i < NUM_BINS; i++) begin
            if (scan_q == IDX_W'(i)) cur_bin = bin_q[i];
        end

        case (state_q)
            ST_ACCUM: begin
                if (in_valid) begin
                    if (in_residue < RES_W'(NUM_BINS)) begin
                        for (int i = 0; i < NUM_BINS; i++) begin
                            if (in_residue == RES_W'(i) && bin_q[i] != {CNT_W{1'b1}})
                                bin_d[i] = bin_q[i] + 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    if (in_last) begin
                        state_d = ST_SCAN;
                        scan_d  = '0;
                    end
                end
            end
            ST_SCAN: begin
                // Strict compare keeps the lowest index on ties.
                if (cur_bin > cnt_q) begin
                    cls_d = CLS_W'(scan_q);
                    cnt_d = cur_bin;
                end
                if (scan_q == IDX_W'(NUM_BINS - 1)) state_d = ST_OUTPUT;
                else scan_d = scan_q + 1'b1;
            end
            ST_OUTPUT: begin
                if (out_ready) begin
                    state_d = ST_ACCUM;
                    for (int i = 0; i < NUM_BINS; i++) bin_d[i] = '0;
                    err_d  = 1'b0;
                    cls_d  = '0;
                    cnt_d  = '0;
                    scan_d = '0;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_ACCUM;
            for (int i = 0; i < NUM_BINS; i++) bin_q[i] <= '0;
            scan_q  <= '0;
            cls_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            scan_q  <= scan_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_OUTPUT);
    assign out_class = cls_q;
    assign out_count = cnt_q;
    assign out_err   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_residue_vote.sv
// Directed bench for residue_vote: frame table plus saturation, backpressure
// and mid-scan reset sequences.
module tb_residue_vote;
  import residue_vote_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_residue;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_class;
  logic [7:0] out_count;
  logic       out_err;
  rv_state_e  dbg_state;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]      n;
    logic [4:0][7:0] res;
    logic [3:0]      cls;
    logic [7:0]      cnt;
    logic            err;
  } vec_t;

  vec_t vecs[8];

  residue_vote dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_residue (in_residue),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_class  (out_class),
    .out_count  (out_count),
    .out_err    (out_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // scoreboard
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input int r0, input int r1, input int r2,
                              input int r3, input int r4, input int cls, input int cnt,
                              input int err);
    vec_t v;
    v.n      = 3'(n);
    v.res[0] = 8'(r0);
    v.res[1] = 8'(r1);
    v.res[2] = 8'(r2);
    v.res[3] = 8'(r3);
    v.res[4] = 8'(r4);
    v.cls    = 4'(cls);
    v.cnt    = 8'(cnt);
    v.err    = 1'(err);
    return v;
  endfunction

  // drivers
  task automatic send_beat(input logic [7:0] r, input logic last);
    in_valid   = 1'b1;
    in_residue = r;
    in_last    = last;
    tick();
    in_valid   = 1'b0;
    in_last    = 1'b0;
  endtask

  // Cycle index after the last-beat edge at which out_valid is first seen.
  task automatic wait_result(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check($sformatf("%s.in_ready_after", tag), 32'(in_ready), 32'd1);
    check($sformatf("%s.out_valid_after", tag), 32'(out_valid), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [3:0] cls,
                              input logic [7:0] cnt, input logic err);
    int cyc;
    wait_result(cyc);
    check($sformatf("%s.latency", tag), 32'(cyc), 32'd15);
    check($sformatf("%s.class", tag), 32'(out_class), 32'(cls));
    check($sformatf("%s.count", tag), 32'(out_count), 32'(cnt));
    check($sformatf("%s.err", tag), 32'(out_err), 32'(err));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    for (int i = 0; i < int'(v.n); i++)
      send_beat(v.res[i], i == int'(v.n) - 1);
    check_result(tag, v.cls, v.cnt, v.err);
    take_result(tag);
  endtask

  initial begin
    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_residue = 8'd0;
    in_last    = 1'b0;
    out_ready  = 1'b0;

    vecs[0] = mk(5, 3, 5, 3, 3, 13, 3, 3, 0);   // majority
    vecs[1] = mk(4, 7, 2, 7, 2, 0, 2, 2, 0);    // tie -> lower index
    vecs[2] = mk(3, 20, 4, 255, 0, 0, 4, 1, 1); // range errors
    vecs[3] = mk(1, 14, 0, 0, 0, 0, 0, 0, 1);   // only an out-of-range beat
    vecs[4] = mk(2, 0, 13, 0, 0, 0, 0, 1, 0);   // tie between first and last bin
    vecs[5] = mk(3, 13, 13, 12, 0, 0, 13, 2, 0);
    vecs[6] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[7] = mk(4, 9, 14, 9, 1, 0, 9, 2, 1);

    tick();
    tick();
    check("reset.out_valid", 32'(out_valid), 32'd0);
    check("reset.out_class", 32'(out_class), 32'd0);
    check("reset.out_count", 32'(out_count), 32'd0);
    check("reset.out_err", 32'(out_err), 32'd0);
    reset_n = 1'b1;
    tick();
    check("reset.in_ready", 32'(in_ready), 32'd1);

    for (int k = 0; k < 8; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));

    // saturation
    for (int k = 0; k < 300; k++) send_beat(8'd9, 1'b0);
    send_beat(8'd9, 1'b1);
    check_result("sat", 4'd9, 8'd255, 1'b0);
    take_result("sat");

    // backpressure: result held, beats offered meanwhile must be ignored
    send_beat(8'd4, 1'b0);
    send_beat(8'd4, 1'b0);
    send_beat(8'd4, 1'b1);
    check_result("bp", 4'd4, 8'd3, 1'b0);
    for (int k = 0; k < 10; k++) begin
      in_valid   = 1'b1;
      in_residue = 8'd5;
      in_last    = (k == 9);
      tick();
      check("bp.hold_valid", 32'(out_valid), 32'd1);
      check("bp.hold_in_ready", 32'(in_ready), 32'd0);
      check("bp.hold_class", 32'(out_class), 32'd4);
      check("bp.hold_count", 32'(out_count), 32'd3);
      check("bp.hold_err", 32'(out_err), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take_result("bp");
    send_beat(8'd1, 1'b0);
    send_beat(8'd1, 1'b1);
    check_result("bp_next", 4'd1, 8'd2, 1'b0);
    take_result("bp_next");

    // reset in the middle of the scan
    send_beat(8'd8, 1'b0);
    send_beat(8'd20, 1'b0);
    send_beat(8'd8, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("rst_scan.out_valid", 32'(out_valid), 32'd0);
    check("rst_scan.in_ready", 32'(in_ready), 32'd1);
    check("rst_scan.out_class", 32'(out_class), 32'd0);
    check("rst_scan.out_count", 32'(out_count), 32'd0);
    check("rst_scan.out_err", 32'(out_err), 32'd0);
    tick();
    check("rst_scan.in_ready_rel", 32'(in_ready), 32'd1);
    send_beat(8'd6, 1'b1);
    check_result("rst_scan_next", 4'd6, 8'd1, 1'b0);
    take_result("rst_scan_next");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
